opcode_sequencer: RTL and testbench
===================================

// Module: opcode_sequencer
// PURPOSE
//  Instruction issuer for the GPU cores: holds a small program of 16-bit opcodes, steps through it
//  and broadcasts each data-path opcode to all cores on the shared opcode/execute bus, one per cycle.
//  Sequencer-only control opcodes (set-loop, loop, halt) are consumed locally and never issued.
//  Sits between the host/config interface and the core array.
// PARAMETERS
//  PROG_DEPTH  32  program memory entries; power of two, 2..256; ADDR_W = $clog2(PROG_DEPTH)
// PORTS
//  clk        in   1       clock
//  reset      in   1       asynchronous, active-high reset
//  load_en    in   1       program write strobe (accepted only in IDLE)
//  load_addr  in   ADDR_W  program write address
//  load_data  in   16      program write data
//  start      in   1       begin execution at address 0 (accepted only in IDLE)
//  stop       in   1       abort execution, return to IDLE
//  hold       in   1       stall: freeze pc, issue nothing this cycle
//  opcode     out  16      opcode broadcast to cores (registered)
//  execute    out  1       opcode valid for cores this cycle (registered)
//  busy       out  1       1 while in RUN
//  done       out  1       one-cycle pulse on HALT
//  pc         out  ADDR_W  current program counter
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, loop_cnt(8b)=0, opcode=0, execute=0, busy=0, done=0. Program memory
//   is not reset. Reset mid-RUN aborts immediately; no further execute pulses.
//  States: IDLE, RUN. execute defaults to 0 every cycle unless an issue occurs; done defaults to 0.
//  IDLE: load_en=1 -> prog[load_addr]<=load_data. start=1 & stop=0 -> pc<=0, RUN (busy=1 next cycle).
//   start and load_en same cycle: write performed and start taken.
//  RUN, priority: stop > hold > decode of instr=prog[pc].
//   stop=1 -> IDLE, execute<=0, pc unchanged. hold=1 -> pc, loop_cnt held, execute<=0.
//   instr[15:14]!=2'b11, or instr[15:12]==4'b1100 (core misc/store): opcode<=instr, execute<=1,
//    pc<=pc+1. Latency: opcode visible with execute one cycle after pc points at it.
//   4'b1101 SETLOOP: loop_cnt<=instr[7:0], pc<=pc+1, no issue.
//   4'b1110 LOOP: loop_cnt!=0 -> loop_cnt<=loop_cnt-1, pc<=instr[ADDR_W-1:0]; else pc<=pc+1.
//    No issue. Body with SETLOOP n therefore runs n+1 times.
//   4'b1111 HALT: -> IDLE, done<=1 (one cycle), no issue, pc unchanged.
//  opcode holds last issued value while execute=0.
//  pc increment wraps PROG_DEPTH-1 -> 0; loop targets truncated to ADDR_W bits (modulo).
//  load_en while RUN ignored (memory unchanged). start while RUN ignored.
//  Control opcodes cost one cycle each with execute=0; cores see gaps, never stale repeats.
// TESTING
//  Load {0x0105,0x4410,0xF000}; start -> execute high 2 cycles (0x0105,0x4410) from cycle 2
//   after start, then done pulse, busy drops, exactly 2 execute pulses.
//  Load {0xD002,0x8000,0xE001,0xF000}; start -> 0x8000 issued exactly 3 times, then done.
//  Run program without HALT at PROG_DEPTH=4 -> pc wraps 3->0, issue stream repeats until stop.
//  Assert hold 3 cycles mid-program -> execute low 3 cycles, pc frozen, no opcode skipped/duplicated.
//  load_en during RUN to addr 1 -> read back via rerun shows old value; stop+start same cycle -> IDLE.
//  Assert reset mid-loop -> execute, busy, done, pc, opcode all 0 immediately; start reruns cleanly.

Source files
------------

// File: rtl/opcode_sequencer.sv
// ---------------------------------------------------------------------------
// opcode_sequencer
//
// Purpose:
//   Instruction issuer for the GPU core array. Holds a small program of
//   16-bit opcodes and steps through it. Each data-path opcode is broadcast
//   on the shared opcode/execute bus, at most one per cycle. The control
//   opcodes SETLOOP (0xD), LOOP (0xE) and HALT (0xF) are consumed locally
//   and are never issued.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   load_en    program write strobe (honoured only while idle)
//   load_addr  program write address
//   load_data  program write data
//   start      begin execution at address 0 (honoured only while idle)
//   stop       abort execution and return to idle
//   hold       stall: freeze pc and loop counter, issue nothing
//   opcode     opcode broadcast to the cores (registered)
//   execute    opcode valid for the cores this cycle (registered)
//   busy       1 while running
//   done       one-cycle pulse when HALT is reached
//   pc         current program counter
// ---------------------------------------------------------------------------
module opcode_sequencer #(
  parameter int PROG_DEPTH = 32,
  localparam int ADDR_W = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  output logic [15:0]       opcode,
  output logic              execute,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        loop_cnt_q, loop_cnt_d;
  logic [15:0]       opcode_q, opcode_d;
  logic              execute_q, execute_d;
  logic              done_q, done_d;

  // Program store. Asynchronous read so the instruction at pc is decoded in
  // the same cycle; the resulting issue is registered, giving one cycle of
  // latency from pc to opcode/execute.
  logic [15:0] prog_mem [PROG_DEPTH];
  logic [15:0] instr;

  assign instr = prog_mem[pc_q];

  // Writes are only accepted while idle so a running program never changes
  // underneath the sequencer. Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && load_en) begin
      prog_mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    opcode_d   = opcode_q;     // opcode keeps the last issued value
    execute_d  = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          pc_d    = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!hold) begin
          case (instr[15:12])
            4'hD: begin  // SETLOOP
              loop_cnt_d = instr[7:0];
              pc_d       = pc_q + ADDR_W'(1);
            end
            4'hE: begin  // LOOP: branch back while the counter is non-zero
              if (loop_cnt_q != 8'd0) begin
                loop_cnt_d = loop_cnt_q - 8'd1;
                pc_d       = instr[ADDR_W-1:0];
              end else begin
                pc_d = pc_q + ADDR_W'(1);
              end
            end
            4'hF: begin  // HALT: pc left pointing at the HALT
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default: begin  // every other encoding, including 0xC, is issued
              opcode_d  = instr;
              execute_d = 1'b1;
              pc_d      = pc_q + ADDR_W'(1);
            end
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      loop_cnt_q <= 8'd0;
      opcode_q   <= 16'd0;
      execute_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      opcode_q   <= opcode_d;
      execute_q  <= execute_d;
      done_q     <= done_d;
    end
  end

  assign opcode  = opcode_q;
  assign execute = execute_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign pc      = pc_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer (4-entry program so pc wrap is reachable).
// Expected issues are queued by the stimulus and consumed by a monitor that
// checks every execute pulse against the head of the queue.
module tb_opcode_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic          start;
  logic          stop;
  logic          hold;
  logic [15:0]   opcode;
  logic          execute;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  opcode_sequencer #(.PROG_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .opcode    (opcode),
    .execute   (execute),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          exec_cnt = 0;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Monitor: every issue must match the next expected opcode.
  always @(negedge clk) begin
    if (execute === 1'b1) begin
      exec_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_issue", {16'd0, opcode}, 32'hFFFF_FFFF);
      end else begin
        chk("issue_opcode", {16'd0, opcode}, {16'd0, sb.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step(1);
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (done === 1'b1) seen = 1;
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_busy_after_done"}, {31'd0, busy}, 32'd0);
    step(1);
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int base;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stop = 1'b0; hold = 1'b0;
    step(2);
    chk("rst_execute", {31'd0, execute}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    chk("rst_pc",      {30'd0, pc},      32'd0);
    chk("rst_opcode",  {16'd0, opcode},  32'd0);
    reset = 1'b0;
    step(1);

    // Basic issue stream with latency check.
    load(0, 16'h0105); load(1, 16'h4410); load(2, 16'hF000);
    sb.push_back(16'h0105); sb.push_back(16'h4410);
    base = exec_cnt;
    pulse_start();
    chk("t1_busy_c1", {31'd0, busy}, 32'd1);
    chk("t1_exec_c1", {31'd0, execute}, 32'd0);
    step(1);
    chk("t1_exec_c2", {31'd0, execute}, 32'd1);
    chk("t1_op_c2",   {16'd0, opcode}, 32'h0105);
    step(1);
    chk("t1_op_c3",   {16'd0, opcode}, 32'h4410);
    step(1);
    chk("t1_done",    {31'd0, done}, 32'd1);
    chk("t1_busy_end",{31'd0, busy}, 32'd0);
    chk("t1_pc_halt", {30'd0, pc}, 32'd2);
    step(1);
    chk("t1_count", exec_cnt - base, 32'd2);

    // SETLOOP 2 -> body runs 3 times.
    load(0, 16'hD002); load(1, 16'h8000); load(2, 16'hE001); load(3, 16'hF000);
    repeat (3) sb.push_back(16'h8000);
    base = exec_cnt;
    pulse_start();
    wait_done("t2", 30);
    chk("t2_count", exec_cnt - base, 32'd3);
    chk("t2_queue_empty", sb.size(), 32'd0);

    // No HALT: pc wraps 3->0 and stream repeats until stop.
    load(0, 16'h0001); load(1, 16'h0002); load(2, 16'h0003); load(3, 16'h0004);
    for (int k = 0; k < 10; k++) sb.push_back(16'(k % 4 + 1));
    base = exec_cnt;
    pulse_start();
    step(10);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("t3_busy_stop", {31'd0, busy}, 32'd0);
    chk("t3_exec_stop", {31'd0, execute}, 32'd0);
    chk("t3_pc_stop",   {30'd0, pc}, 32'd2);
    step(2);
    chk("t3_count", exec_cnt - base, 32'd10);
    chk("t3_queue_empty", sb.size(), 32'd0);

    // Hold for 3 cycles mid-program.
    load(0, 16'h0011); load(1, 16'h0022); load(2, 16'h0033); load(3, 16'hF000);
    sb.push_back(16'h0011); sb.push_back(16'h0022); sb.push_back(16'h0033);
    base = exec_cnt;
    pulse_start();
    step(1);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("t4_hold_exec", {31'd0, execute}, 32'd0);
      chk("t4_hold_pc",   {30'd0, pc}, 32'd1);
      chk("t4_hold_op",   {16'd0, opcode}, 32'h0011);
    end
    hold = 1'b0;
    wait_done("t4", 20);
    chk("t4_count", exec_cnt - base, 32'd3);

    // load_en during RUN is ignored; rerun shows the old contents.
    sb.push_back(16'h0011); sb.push_back(16'h0022); sb.push_back(16'h0033);
    start = 1'b1;
    step(1);
    start = 1'b0;
    load_en = 1'b1; load_addr = 1; load_data = 16'h0099;
    step(1);
    load_en = 1'b0;
    wait_done("t5a", 20);
    sb.push_back(16'h0011); sb.push_back(16'h0022); sb.push_back(16'h0033);
    pulse_start();
    wait_done("t5b", 20);
    chk("t5_queue_empty", sb.size(), 32'd0);

    // stop and start together while idle: stays idle.
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    step(1);
    chk("t6_exec", {31'd0, execute}, 32'd0);

    // Async reset mid-loop, then a clean rerun.
    load(0, 16'hD002); load(1, 16'h8000); load(2, 16'hE001); load(3, 16'hF000);
    sb.push_back(16'h8000);
    pulse_start();
    step(3);
    #2 reset = 1'b1;
    #1;
    chk("t7_rst_exec", {31'd0, execute}, 32'd0);
    chk("t7_rst_busy", {31'd0, busy}, 32'd0);
    chk("t7_rst_done", {31'd0, done}, 32'd0);
    chk("t7_rst_pc",   {30'd0, pc}, 32'd0);
    chk("t7_rst_op",   {16'd0, opcode}, 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("t7_queue_after_rst", sb.size(), 32'd0);
    repeat (3) sb.push_back(16'h8000);
    base = exec_cnt;
    pulse_start();
    wait_done("t7", 30);
    chk("t7_count", exec_cnt - base, 32'd3);
    chk("final_queue_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
